bcd_down_timer: RTL and testbench

Multi-digit BCD countdown timer: the decrementing counterpart of the team's decade up-counter. Loads a BCD start value and, once started, decrements by one on each qualified tick (`en`). On reaching zero it stops and pulses `done`. Sits beside the up-counter chain as the countdown/timeout source for control logic.

---
 rtl/timer_pkg.sv | 25 ++
 rtl/bcd_dn_digit.sv | 46 ++++
 rtl/bcd_down_timer.sv | 107 ++++++++++
 tb/tb_bcd_down_timer.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the BCD countdown timer: FSM state encoding,
// digit width constants and the digit clamp applied at load time.
package timer_pkg;

  localparam int         DIGIT_W   = 4;
  localparam logic [3:0] DIGIT_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // A loaded nibble outside 0..9 is forced to 9.
  function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] d);
    logic [DIGIT_W-1:0] r;
    if (d > DIGIT_MAX) begin
      r = DIGIT_MAX;
    end else begin
      r = d;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_dn_digit.sv
// One decade down-counting cell: load (clamped), decrement with 0 -> 9 wrap,
// or hold. The borrow into higher digits is decided by the parent.
module bcd_dn_digit
  import timer_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               dec,
  input  logic               ld,
  input  logic [DIGIT_W-1:0] ld_val,
  output logic [DIGIT_W-1:0] digit,
  output logic               is_zero
);

  logic [DIGIT_W-1:0] digit_q;
  logic [DIGIT_W-1:0] digit_d;

  // Next digit value: load wins over decrement.
  always_comb begin
    digit_d = digit_q;
    if (ld) begin
      digit_d = clamp_digit(ld_val);
    end else if (dec) begin
      if (digit_q == 4'd0) begin
        digit_d = DIGIT_MAX;
      end else begin
        digit_d = digit_q - 4'd1;
      end
    end else begin
      digit_d = digit_q;
    end
  end

  // Digit register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      digit_q <= 4'd0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit   = digit_q;
  assign is_zero = (digit_q == 4'd0);

endmodule

// File: rtl/bcd_down_timer.sv
// Multi-digit BCD countdown timer: load, start, decrement on qualified ticks,
// one-cycle done pulse on expiry. The FSM and borrow chain live here.
module bcd_down_timer
  import timer_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      load,
  input  logic [DIGIT_W*DIGITS-1:0] load_val,
  input  logic                      start,
  output logic [DIGIT_W*DIGITS-1:0] count,
  output logic                      busy,
  output logic                      done,
  output logic                      zero
);

  localparam logic [DIGIT_W*DIGITS-1:0] ONE_C = {{(DIGIT_W*DIGITS-1){1'b0}}, 1'b1};

  state_e state_q;
  state_e state_d;
  logic   busy_q, busy_d;
  logic   done_q, done_d;

  logic [DIGITS-1:0] dig_zero_s;
  logic [DIGITS-1:0] dec_s;
  logic [DIGITS:0]   lower_zero_s;
  logic              tick_s;
  logic              count_one_s;

  // lower_zero_s[i] is high when every digit below i is zero.
  always_comb begin
    lower_zero_s[0] = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      lower_zero_s[i+1] = lower_zero_s[i] & dig_zero_s[i];
    end
  end

  assign zero        = lower_zero_s[DIGITS];
  assign count_one_s = (count == ONE_C);
  // The !zero term keeps the count from ever wrapping past 0 at the top.
  assign tick_s      = (state_q == RUN) & en & ~load & ~zero;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    assign dec_s[g] = tick_s & lower_zero_s[g];

    bcd_dn_digit u_digit (
      .clk     (clk),
      .rst     (rst),
      .dec     (dec_s[g]),
      .ld      (load),
      .ld_val  (load_val[DIGIT_W*g +: DIGIT_W]),
      .digit   (count[DIGIT_W*g +: DIGIT_W]),
      .is_zero (dig_zero_s[g])
    );
  end

  // Next-state and registered-output decode.
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = zero ? DONE : RUN;
          end else begin
            state_d = IDLE;
          end
        end
        RUN: begin
          if (en && count_one_s) begin
            state_d = DONE;
          end else if (zero) begin
            state_d = IDLE;
          end else begin
            state_d = RUN;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_bcd_down_timer.sv
// Self-checking bench for bcd_down_timer: directed scenarios plus random
// traffic, compared each cycle against an integer-valued reference model.
module tb_bcd_down_timer;

  logic        clk = 1'b0;
  logic        rst, en, load, start;
  logic [15:0] load_val;
  logic [15:0] count;
  logic        busy, done, zero;

  int n_checks = 0;
  int n_fail   = 0;

  int m_val  = 0;
  bit m_run  = 1'b0;
  bit m_done = 1'b0;

  bcd_down_timer #(.DIGITS(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .start    (start),
    .count    (count),
    .busy     (busy),
    .done     (done),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int bcd_to_int(input logic [15:0] v);
    int r = 0;
    for (int i = 3; i >= 0; i--) begin
      int d = int'(v[4*i +: 4]);
      if (d > 9) d = 9;
      r = r * 10 + d;
    end
    return r;
  endfunction

  function automatic logic [15:0] int_to_bcd(input int v);
    logic [15:0] b = 16'h0000;
    int t = v;
    for (int i = 0; i < 4; i++) begin
      b[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return b;
  endfunction

  // Reference behaviour expressed on a plain integer count.
  task automatic model_edge(input logic r, input logic l, input logic [15:0] lv,
                            input logic s, input logic e);
    if (r) begin
      m_val = 0; m_run = 1'b0; m_done = 1'b0;
    end else if (l) begin
      m_val = bcd_to_int(lv); m_run = 1'b0; m_done = 1'b0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (!m_run) begin
      if (s) begin
        if (m_val == 0) m_done = 1'b1;
        else            m_run  = 1'b1;
      end
    end else if (e) begin
      m_val = m_val - 1;
      if (m_val == 0) begin
        m_run = 1'b0; m_done = 1'b1;
      end
    end
  endtask

  task automatic step(input logic r, input logic l, input logic [15:0] lv,
                      input logic s, input logic e);
    rst = r; load = l; load_val = lv; start = s; en = e;
    @(posedge clk);
    model_edge(r, l, lv, s, e);
    #1;
    check_eq("count", count, int_to_bcd(m_val));
    check_eq("busy",  {15'd0, busy}, {15'd0, m_run});
    check_eq("done",  {15'd0, done}, {15'd0, m_done});
    check_eq("zero",  {15'd0, zero}, {15'd0, (m_val == 0)});
  endtask

  initial begin
    logic [15:0] lv;
    rst = 1'b1; en = 1'b0; load = 1'b0; start = 1'b0; load_val = 16'h0000;

    // Reset with random inputs, then a short 3-count run.
    for (int i = 0; i < 3; i++) step(1'b1, 1'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    check_eq("rst_count", count, 16'h0000);
    check_eq("rst_zero", {15'd0, zero}, 16'd1);
    step(1'b0, 1'b1, 16'h0003, 1'b0, 1'b0);
    step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    check_eq("start_busy", {15'd0, busy}, 16'd1);
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    check_eq("cnt2", count, 16'h0002);
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    check_eq("cnt0_done", {count[14:0], done}, 16'h0001);
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    check_eq("done_fall", {14'd0, busy, done}, 16'd0);

    // Borrow ripple across all digits.
    step(1'b0, 1'b1, 16'h1000, 1'b0, 1'b0);
    step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    check_eq("ripple", count, 16'h0999);
    for (int i = 0; i < 999; i++) step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    check_eq("ripple_done", {count[14:0], done}, 16'h0001);
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);

    // Gated ticks: en high on every second edge after start.
    step(1'b0, 1'b1, 16'h0005, 1'b0, 1'b0);
    step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    for (int k = 1; k <= 10; k++) step(1'b0, 1'b0, 16'h0000, 1'b0, 1'((k % 2) == 0));
    check_eq("gate_done", {15'd0, done}, 16'd1);
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);

    // Clamp and immediate expiry.
    step(1'b0, 1'b1, 16'h0A0F, 1'b0, 1'b0);
    check_eq("clamp", count, 16'h0909);
    step(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
    step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    check_eq("imm_done", {14'd0, busy, done}, 16'd1);
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);

    // Load abort mid-run.
    step(1'b0, 1'b1, 16'h0050, 1'b0, 1'b0);
    step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    check_eq("abort_pre", count, 16'h0042);
    step(1'b0, 1'b1, 16'h0007, 1'b1, 1'b1);
    check_eq("abort_cnt", count, 16'h0007);
    check_eq("abort_flags", {14'd0, busy, done}, 16'd0);
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    check_eq("abort_hold", count, 16'h0007);

    // Reset beats load and en mid-run.
    step(1'b0, 1'b1, 16'h0100, 1'b0, 1'b0);
    step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    step(1'b1, 1'b1, 16'h0055, 1'b0, 1'b1);
    check_eq("rstpri", {count[13:0], busy, done}, 16'd0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(1) == 0) lv = int_to_bcd($urandom_range(20));
      else                        lv = 16'($urandom);
      step(1'($urandom_range(63) == 0), 1'($urandom_range(15) == 0), lv,
           1'($urandom_range(3) == 0), 1'($urandom_range(1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
